// File: rtl/audio_sample_writer.sv
// rtl/audio_sample_writer.sv - I2S left-channel capture into sample RAM, one frame per consumer ack
module audio_sample_writer #(
  parameter int          FRAME_LEN = 16,
  parameter logic [14:0] BASE_ADDR = 15'h0000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        i2s_sclk,
  input  logic        i2s_lrclk,
  input  logic        i2s_sdin,
  input  logic        frame_ack,
  output logic [14:0] RAM_ADDR,
  output logic [15:0] RAM_DATA,
  output logic        RAM_WREN,
  output logic        frame_ready,
  output logic [7:0]  dropped_count
);

  localparam logic [14:0] LAST_IDX = 15'(FRAME_LEN - 1);
  localparam logic [4:0]  BIT_IDLE = 5'd17;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_WRITE,
    S_DONE
  } state_t;

  logic        r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic        r_lr_s1, r_lr_s2;
  logic        r_sd_s1, r_sd_s2;
  logic        r_lr_prev;
  logic [4:0]  r_bitcnt;
  logic [15:0] r_shift;
  logic        r_word_done;
  state_t      r_state;
  logic [14:0] r_wr_idx;

  logic w_sclk_rise;
  logic w_lr_change;

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
  assign w_lr_change = r_lr_s2 != r_lr_prev;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_s3 <= 1'b0;
      r_lr_s1   <= 1'b0;
      r_lr_s2   <= 1'b0;
      r_sd_s1   <= 1'b0;
      r_sd_s2   <= 1'b0;
    end else begin
      r_sclk_s1 <= i2s_sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_lr_s1   <= i2s_lrclk;
      r_lr_s2   <= r_lr_s1;
      r_sd_s1   <= i2s_sdin;
      r_sd_s2   <= r_sd_s1;
    end
  end

  // The lrclk-change edge is the I2S delay slot; only the 16 edges after it shift data.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_lr_prev   <= 1'b0;
      r_bitcnt    <= BIT_IDLE;
      r_shift     <= 16'h0000;
      r_word_done <= 1'b0;
    end else begin
      r_word_done <= 1'b0;
      if (w_sclk_rise) begin
        if (w_lr_change) begin
          r_lr_prev <= r_lr_s2;
          r_bitcnt  <= 5'd0;
        end else if (r_bitcnt != BIT_IDLE) begin
          r_bitcnt <= r_bitcnt + 5'd1;
          if (r_bitcnt < 5'd16) begin
            r_shift <= {r_shift[14:0], r_sd_s2};
          end
          if (r_bitcnt == 5'd15 && !r_lr_prev) begin
            r_word_done <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state       <= S_IDLE;
      r_wr_idx      <= 15'd0;
      RAM_ADDR      <= 15'd0;
      RAM_DATA      <= 16'h0000;
      RAM_WREN      <= 1'b0;
      frame_ready   <= 1'b0;
      dropped_count <= 8'd0;
    end else begin
      RAM_WREN <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_wr_idx <= 15'd0;
          r_state  <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (r_word_done) begin
            RAM_DATA <= r_shift;
            RAM_ADDR <= BASE_ADDR + r_wr_idx;
            RAM_WREN <= 1'b1;
            r_state  <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (r_wr_idx == LAST_IDX) begin
            frame_ready <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_wr_idx <= r_wr_idx + 15'd1;
            r_state  <= S_CAPTURE;
          end
        end
        S_DONE: begin
          // A word finishing in the ack cycle is still dropped; the next frame starts clean.
          if (r_word_done && dropped_count != 8'hFF) begin
            dropped_count <= dropped_count + 8'd1;
          end
          if (frame_ack) begin
            r_wr_idx    <= 15'd0;
            frame_ready <= 1'b0;
            r_state     <= S_CAPTURE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_sample_writer.sv
// tb/tb_audio_sample_writer.sv - randomized I2S stimulus against a frame-level model of the sample writer
module tb_audio_sample_writer;

  typedef logic [30:0] wr_t;

  logic        clk = 1'b0;
  logic        rst0_n, rst1_n, sclk, lrclk, sdin, ack0, ack1;
  logic [14:0] addr0, addr1;
  logic [15:0] data0, data1;
  logic        wren0, wren1, rdy0, rdy1;
  logic [7:0]  drop0, drop1;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int last_wr_cyc0 = -1;
  int rdy_rise_cyc0 = -1;
  logic rdy0_d = 1'b0;

  wr_t obs0[$], obs1[$], exp0[$], exp1[$];

  int m_idx = 0, m_drop = 0, m1_idx = 0, m1_drop = 0;
  bit m_wait = 0, m1_wait = 0, m1_on = 0;

  logic [14:0] snap_addr;
  logic [15:0] snap_data;
  logic        snap_wren, snap_rdy;
  logic [7:0]  snap_drop;

  always #5 clk = ~clk;

  audio_sample_writer #(.FRAME_LEN(16), .BASE_ADDR(15'h0000)) u_dut0 (
    .Clk(clk), .Reset_n(rst0_n), .i2s_sclk(sclk), .i2s_lrclk(lrclk), .i2s_sdin(sdin),
    .frame_ack(ack0), .RAM_ADDR(addr0), .RAM_DATA(data0), .RAM_WREN(wren0),
    .frame_ready(rdy0), .dropped_count(drop0)
  );

  audio_sample_writer #(.FRAME_LEN(4), .BASE_ADDR(15'h7FFE)) u_dut1 (
    .Clk(clk), .Reset_n(rst1_n), .i2s_sclk(sclk), .i2s_lrclk(lrclk), .i2s_sdin(sdin),
    .frame_ack(ack1), .RAM_ADDR(addr1), .RAM_DATA(data1), .RAM_WREN(wren1),
    .frame_ready(rdy1), .dropped_count(drop1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wren0 === 1'b1) begin
      obs0.push_back({addr0, data0});
      last_wr_cyc0 = cyc;
    end
    if (wren1 === 1'b1) obs1.push_back({addr1, data1});
    if (rdy0 === 1'b1 && rdy0_d !== 1'b1) rdy_rise_cyc0 = cyc;
    rdy0_d = rdy0;
  end

  // Frame-level reference: each completed left word either fills the next slot or is dropped.
  task automatic model_left(input logic [15:0] w, input bit with_ack, input bit dut0_reset);
    int a;
    if (dut0_reset) begin
      m_idx = 0; m_wait = 0; m_drop = 0;
    end else if (m_wait) begin
      if (m_drop < 255) m_drop++;
      if (with_ack) begin m_wait = 0; m_idx = 0; end
    end else begin
      exp0.push_back({15'(m_idx % 32768), w});
      m_idx++;
      if (m_idx == 16) m_wait = 1;
    end
    if (m1_on) begin
      if (m1_wait) begin
        if (m1_drop < 255) m1_drop++;
      end else begin
        a = (32'h7FFE + m1_idx) % 32768;
        exp1.push_back({15'(a), w});
        m1_idx++;
        if (m1_idx == 4) m1_wait = 1;
      end
    end
  endtask

  // One sclk period of 6 Clk cycles; every call starts 3 time units after a Clk rising edge.
  task automatic sclk_bit(input logic lr, input logic d);
    lrclk = lr;
    sdin  = d;
    repeat (3) @(posedge clk);
    #3 sclk = 1'b1;
    repeat (3) @(posedge clk);
    #3 sclk = 1'b0;
  endtask

  task automatic send_slot(input logic lr, input logic [15:0] w, input int pad,
                           input bit ack_on_last, input bit rst_after8);
    sclk_bit(lr, 1'($urandom_range(0, 1)));
    for (int i = 15; i >= 0; i--) begin
      sclk_bit(lr, w[i]);
      if (i == 0 && ack_on_last) begin
        ack0 = 1'b1;
        @(posedge clk);
        #3 ack0 = 1'b0;
      end
      if (i == 8 && rst_after8) begin
        rst0_n = 1'b0;
        #1;
        snap_addr = addr0; snap_data = data0; snap_wren = wren0;
        snap_rdy = rdy0; snap_drop = drop0;
        @(posedge clk);
        #3 rst0_n = 1'b1;
      end
    end
    for (int i = 0; i < pad; i++) sclk_bit(lr, 1'b1);
  endtask

  task automatic send_frame(input logic [15:0] left, input logic [15:0] right, input int pad,
                            input bit with_ack, input bit rst_mid);
    send_slot(1'b0, left, pad, with_ack, rst_mid);
    model_left(left, with_ack, rst_mid);
    send_slot(1'b1, right, pad, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    total++; if (addr0 !== 15'd0) $display("FAIL reset_addr: got %h want 0000", addr0); else passed++;
    total++; if (data0 !== 16'd0) $display("FAIL reset_data: got %h want 0000", data0); else passed++;
    total++; if (wren0 !== 1'b0) $display("FAIL reset_wren: got %b want 0", wren0); else passed++;
    total++; if (rdy0 !== 1'b0) $display("FAIL reset_ready: got %b want 0", rdy0); else passed++;
    total++; if (drop0 !== 8'd0) $display("FAIL reset_dropped: got %0d want 0", drop0); else passed++;
    #2 rst0_n = 1'b1;
    @(posedge clk);
    #3;
    send_slot(1'b1, 16'h0000, 0, 1'b0, 1'b0);
  endtask

  task automatic test_frame_fill;
    logic [15:0] w;
    obs0.delete(); exp0.delete();
    for (int i = 0; i < 16; i++) begin
      w = 16'(i + 1);
      if (i % 2 == 0) w[15] = 1'b1;
      send_frame(w, 16'($urandom), 15, 1'b0, 1'b0);
    end
    total++; if (rdy0 !== 1'b1) $display("FAIL fill_ready: got %b want 1", rdy0); else passed++;
    total++;
    if (rdy_rise_cyc0 != last_wr_cyc0 + 1)
      $display("FAIL fill_ready_timing: rise cycle %0d, want %0d", rdy_rise_cyc0, last_wr_cyc0 + 1);
    else passed++;
    @(posedge clk);
    #3 ack0 = 1'b1;
    @(posedge clk);
    #1;
    total++; if (rdy0 !== 1'b0) $display("FAIL fill_ack_clear: got %b want 0", rdy0); else passed++;
    #2 ack0 = 1'b0;
    m_wait = 0; m_idx = 0;
    send_frame(16'($urandom), 16'($urandom), 15, 1'b0, 1'b0);
    total++;
    if (obs0.size() != exp0.size()) $display("FAIL fill_count: got %0d writes want %0d", obs0.size(), exp0.size());
    else passed++;
    for (int i = 0; i < obs0.size() && i < exp0.size(); i++) begin
      total++;
      if (obs0[i] !== exp0[i])
        $display("FAIL fill_wr[%0d]: got addr=%h data=%h want addr=%h data=%h", i,
                 obs0[i][30:16], obs0[i][15:0], exp0[i][30:16], exp0[i][15:0]);
      else passed++;
    end
  endtask

  task automatic test_bit_align;
    obs0.delete(); exp0.delete();
    send_frame(16'hA5C3, 16'hFFFF, 8, 1'b0, 1'b0);
    total++;
    if (obs0.size() != 1) $display("FAIL align_count: got %0d writes want 1", obs0.size());
    else passed++;
    if (obs0.size() == 1) begin
      total++;
      if (obs0[0][15:0] !== 16'hA5C3) $display("FAIL align_data: got %h want a5c3", obs0[0][15:0]);
      else passed++;
      total++;
      if (obs0[0] !== exp0[0])
        $display("FAIL align_wr: got addr=%h want addr=%h", obs0[0][30:16], exp0[0][30:16]);
      else passed++;
    end
  endtask

  task automatic test_overrun;
    obs0.delete(); exp0.delete();
    for (int i = 0; i < 314; i++) send_frame(16'($urandom), 16'($urandom), 0, 1'b0, 1'b0);
    total++; if (drop0 !== 8'(m_drop)) $display("FAIL overrun_dropped: got %0d want %0d", drop0, m_drop); else passed++;
    total++; if (rdy0 !== 1'b1) $display("FAIL overrun_ready: got %b want 1", rdy0); else passed++;
    total++;
    if (obs0.size() != exp0.size()) $display("FAIL overrun_count: got %0d writes want %0d", obs0.size(), exp0.size());
    else passed++;
    for (int i = 0; i < obs0.size() && i < exp0.size(); i++) begin
      total++;
      if (obs0[i] !== exp0[i])
        $display("FAIL overrun_wr[%0d]: got addr=%h data=%h want addr=%h data=%h", i,
                 obs0[i][30:16], obs0[i][15:0], exp0[i][30:16], exp0[i][15:0]);
      else passed++;
    end
    @(posedge clk);
    #3 ack0 = 1'b1;
    @(posedge clk);
    #3 ack0 = 1'b0;
    m_wait = 0; m_idx = 0;
    total++; if (drop0 !== 8'hFF) $display("FAIL overrun_hold: got %0d want 255", drop0); else passed++;
    rst0_n = 1'b0;
    @(posedge clk);
    #3 rst0_n = 1'b1;
    m_idx = 0; m_wait = 0; m_drop = 0;
    total++; if (drop0 !== 8'(m_drop)) $display("FAIL overrun_reset: got %0d want %0d", drop0, m_drop); else passed++;
    send_slot(1'b1, 16'h0000, 0, 1'b0, 1'b0);
  endtask

  task automatic test_simultaneous_ack;
    obs0.delete(); exp0.delete();
    for (int i = 0; i < 16; i++) send_frame(16'($urandom), 16'($urandom), 0, 1'b0, 1'b0);
    total++; if (rdy0 !== 1'b1) $display("FAIL simul_ready_before: got %b want 1", rdy0); else passed++;
    send_frame(16'($urandom), 16'($urandom), 0, 1'b1, 1'b0);
    total++; if (drop0 !== 8'(m_drop)) $display("FAIL simul_dropped: got %0d want %0d", drop0, m_drop); else passed++;
    total++; if (rdy0 !== 1'b0) $display("FAIL simul_ready_after: got %b want 0", rdy0); else passed++;
    send_frame(16'($urandom), 16'($urandom), 0, 1'b0, 1'b0);
    total++;
    if (obs0.size() != exp0.size()) $display("FAIL simul_count: got %0d writes want %0d", obs0.size(), exp0.size());
    else passed++;
    for (int i = 0; i < obs0.size() && i < exp0.size(); i++) begin
      total++;
      if (obs0[i] !== exp0[i])
        $display("FAIL simul_wr[%0d]: got addr=%h data=%h want addr=%h data=%h", i,
                 obs0[i][30:16], obs0[i][15:0], exp0[i][30:16], exp0[i][15:0]);
      else passed++;
    end
  endtask

  task automatic test_mid_reset;
    obs0.delete(); exp0.delete();
    for (int i = 0; i < 4; i++) send_frame(16'($urandom) | 16'h0001, 16'($urandom), 0, 1'b0, 1'b0);
    send_frame(16'($urandom), 16'($urandom), 0, 1'b0, 1'b1);
    total++; if (snap_addr !== 15'd0) $display("FAIL midrst_addr: got %h want 0000", snap_addr); else passed++;
    total++; if (snap_data !== 16'd0) $display("FAIL midrst_data: got %h want 0000", snap_data); else passed++;
    total++; if (snap_wren !== 1'b0) $display("FAIL midrst_wren: got %b want 0", snap_wren); else passed++;
    total++; if (snap_rdy !== 1'b0) $display("FAIL midrst_ready: got %b want 0", snap_rdy); else passed++;
    total++; if (snap_drop !== 8'd0) $display("FAIL midrst_dropped: got %0d want 0", snap_drop); else passed++;
    send_frame(16'($urandom), 16'($urandom), 0, 1'b0, 1'b0);
    total++;
    if (obs0.size() != exp0.size()) $display("FAIL midrst_count: got %0d writes want %0d", obs0.size(), exp0.size());
    else passed++;
    for (int i = 0; i < obs0.size() && i < exp0.size(); i++) begin
      total++;
      if (obs0[i] !== exp0[i])
        $display("FAIL midrst_wr[%0d]: got addr=%h data=%h want addr=%h data=%h", i,
                 obs0[i][30:16], obs0[i][15:0], exp0[i][30:16], exp0[i][15:0]);
      else passed++;
    end
  endtask

  task automatic test_wrap;
    obs1.delete(); exp1.delete();
    rst1_n = 1'b1;
    send_slot(1'b1, 16'h0000, 0, 1'b0, 1'b0);
    m1_on = 1;
    for (int i = 0; i < 5; i++) send_frame(16'($urandom), 16'($urandom), 8, 1'b0, 1'b0);
    total++; if (rdy1 !== 1'b1) $display("FAIL wrap_ready: got %b want 1", rdy1); else passed++;
    total++; if (drop1 !== 8'(m1_drop)) $display("FAIL wrap_dropped: got %0d want %0d", drop1, m1_drop); else passed++;
    total++;
    if (obs1.size() != exp1.size()) $display("FAIL wrap_count: got %0d writes want %0d", obs1.size(), exp1.size());
    else passed++;
    for (int i = 0; i < obs1.size() && i < exp1.size(); i++) begin
      total++;
      if (obs1[i] !== exp1[i])
        $display("FAIL wrap_wr[%0d]: got addr=%h data=%h want addr=%h data=%h", i,
                 obs1[i][30:16], obs1[i][15:0], exp1[i][30:16], exp1[i][15:0]);
      else passed++;
    end
  endtask

  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0;
    sclk = 1'b0; lrclk = 1'b0; sdin = 1'b0;
    ack0 = 1'b0; ack1 = 1'b0;
    test_reset;
    test_frame_fill;
    test_bit_align;
    test_overrun;
    test_simultaneous_ack;
    test_mid_reset;
    test_wrap;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
